// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order instruction queue issuing to RS, LSB, RoB and RF rename
module dispatch_queue #(
    parameter int IQ_WIDTH  = 2,
    parameter int RoB_WIDTH = 3,
    parameter int NUM_CDB   = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         in_valid,
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_imm,
    input  logic [6:0]                   in_opcode,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [4:0]                   in_rd,
    input  logic                         in_predict,
    output logic                         in_ready,
    output logic [4:0]                   RF_rs1,
    output logic [4:0]                   RF_rs2,
    input  logic [RoB_WIDTH:0]           RF_Qj,
    input  logic [RoB_WIDTH:0]           RF_Qk,
    input  logic [31:0]                  RF_Vj,
    input  logic [31:0]                  RF_Vk,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*RoB_WIDTH-1:0] cdb_rob,
    input  logic [NUM_CDB*32-1:0]        cdb_data,
    input  logic                         RoB_isFull,
    input  logic                         RS_isFull,
    input  logic                         LSB_isFull,
    input  logic                         RoB_flush_signal,
    input  logic [RoB_WIDTH-1:0]         RoB_newEntryIndex,
    output logic                         RS_newEntry_en,
    output logic [RoB_WIDTH-1:0]         RS_robIndex,
    output logic [6:0]                   RS_opcode,
    output logic [31:0]                  RS_Vj,
    output logic [31:0]                  RS_Vk,
    output logic [RoB_WIDTH:0]           RS_Qj,
    output logic [RoB_WIDTH:0]           RS_Qk,
    output logic [31:0]                  RS_imm,
    output logic [31:0]                  RS_pc,
    output logic                         LSB_newEntry_en,
    output logic [RoB_WIDTH-1:0]         LSB_robIndex,
    output logic [6:0]                   LSB_opcode,
    output logic [31:0]                  LSB_Vj,
    output logic [31:0]                  LSB_Vk,
    output logic [RoB_WIDTH:0]           LSB_Qj,
    output logic [RoB_WIDTH:0]           LSB_Qk,
    output logic [31:0]                  LSB_imm,
    output logic [31:0]                  LSB_pc,
    output logic                         RoB_newEntry_en,
    output logic [6:0]                   RoB_opcode,
    output logic [4:0]                   RoB_rd,
    output logic [31:0]                  RoB_pc,
    output logic [31:0]                  RoB_next_pc,
    output logic                         RoB_predict,
    output logic                         RoB_already_ready,
    output logic [31:0]                  RoB_ready_data,
    output logic                         RF_newEntry_en,
    output logic [RoB_WIDTH-1:0]         RF_newEntry_robIndex,
    output logic [4:0]                   RF_newEntry_rd,
    output logic [IQ_WIDTH:0]            count
);
    localparam int DEPTH = 1 << IQ_WIDTH;
    localparam logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

    // Opcode table: RV32I order, lui=1 .. and=37
    localparam logic [6:0] OP_LUI   = 7'd1;
    localparam logic [6:0] OP_AUIPC = 7'd2;
    localparam logic [6:0] OP_JAL   = 7'd3;
    localparam logic [6:0] OP_JALR  = 7'd4;
    localparam logic [6:0] OP_BEQ   = 7'd5;
    localparam logic [6:0] OP_BGEU  = 7'd10;
    localparam logic [6:0] OP_LB    = 7'd11;
    localparam logic [6:0] OP_LHU   = 7'd15;
    localparam logic [6:0] OP_SB    = 7'd16;
    localparam logic [6:0] OP_SW    = 7'd18;
    localparam logic [6:0] OP_ADDI  = 7'd19;
    localparam logic [6:0] OP_SRAI  = 7'd27;

    logic [31:0]         q_pc     [DEPTH];
    logic [31:0]         q_imm    [DEPTH];
    logic [6:0]          q_op     [DEPTH];
    logic [4:0]          q_rs1    [DEPTH];
    logic [4:0]          q_rs2    [DEPTH];
    logic [4:0]          q_rd     [DEPTH];
    logic                q_pred   [DEPTH];
    logic [IQ_WIDTH-1:0] head, tail;

    logic [31:0] h_pc, h_imm, upper;
    logic [6:0]  h_op;
    logic [4:0]  h_rs1, h_rs2, h_rd;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_itype;
    logic        single_src, to_lsb, rob_only, target_free, do_enq, do_deq;
    logic [31:0] vj, vk, rob_npc, rob_data;
    logic [RoB_WIDTH:0] qj, qk;

    assign h_pc  = q_pc[head];
    assign h_imm = q_imm[head];
    assign h_op  = q_op[head];
    assign h_rs1 = q_rs1[head];
    assign h_rs2 = q_rs2[head];
    assign h_rd  = q_rd[head];

    assign is_lui    = (h_op == OP_LUI);
    assign is_auipc  = (h_op == OP_AUIPC);
    assign is_jal    = (h_op == OP_JAL);
    assign is_jalr   = (h_op == OP_JALR);
    assign is_branch = (h_op >= OP_BEQ) && (h_op <= OP_BGEU);
    assign is_load   = (h_op >= OP_LB) && (h_op <= OP_LHU);
    assign is_store  = (h_op >= OP_SB) && (h_op <= OP_SW);
    assign is_itype  = (h_op >= OP_ADDI) && (h_op <= OP_SRAI);

    assign single_src = is_load | is_jalr | is_itype;
    assign to_lsb     = is_load | is_store;
    assign rob_only   = is_lui | is_auipc | is_jal;
    assign target_free = rob_only ? 1'b1 : (to_lsb ? !LSB_isFull : !RS_isFull);

    // Occupancy never exceeds DEPTH, so the top bit alone marks "full"
    assign in_ready = (count[IQ_WIDTH] == 1'b0);
    assign do_enq   = in_valid && in_ready && rdy_in && !RoB_flush_signal;
    assign do_deq   = (count != '0) && rdy_in && !RoB_flush_signal && !RoB_isFull && target_free;

    assign RF_rs1 = (count != '0) ? h_rs1 : 5'd0;
    assign RF_rs2 = (count != '0) ? h_rs2 : 5'd0;

    assign upper    = {h_imm[19:0], 12'b0};
    assign rob_npc  = (is_branch || is_jal) ? h_pc + h_imm : h_pc + 32'd4;
    assign rob_data = is_lui ? upper : is_auipc ? h_pc + upper : is_jal ? h_pc + 32'd4 : 32'd0;

    // Descending scan so the lowest-numbered matching broadcast channel wins
    always_comb begin
        vj = RF_Vj;
        qj = RF_Qj;
        vk = RF_Vk;
        qk = RF_Qk;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (RF_Qj != NON_DEP && cdb_valid[i] && cdb_rob[i*RoB_WIDTH +: RoB_WIDTH] == RF_Qj[RoB_WIDTH-1:0]) begin
                vj = cdb_data[i*32 +: 32];
                qj = NON_DEP;
            end
            if (RF_Qk != NON_DEP && cdb_valid[i] && cdb_rob[i*RoB_WIDTH +: RoB_WIDTH] == RF_Qk[RoB_WIDTH-1:0]) begin
                vk = cdb_data[i*32 +: 32];
                qk = NON_DEP;
            end
        end
        if (h_rs1 == 5'd0) begin
            vj = 32'd0;
            qj = NON_DEP;
        end
        if (h_rs2 == 5'd0 || single_src) begin
            vk = 32'd0;
            qk = NON_DEP;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_enq) begin
            q_pc[tail]   <= in_pc;
            q_imm[tail]  <= in_imm;
            q_op[tail]   <= in_opcode;
            q_rs1[tail]  <= in_rs1;
            q_rs2[tail]  <= in_rs2;
            q_rd[tail]   <= in_rd;
            q_pred[tail] <= in_predict;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            RS_newEntry_en       <= 1'b0;
            RS_robIndex          <= '0;
            RS_opcode            <= '0;
            RS_Vj                <= '0;
            RS_Vk                <= '0;
            RS_Qj                <= '0;
            RS_Qk                <= '0;
            RS_imm               <= '0;
            RS_pc                <= '0;
            LSB_newEntry_en      <= 1'b0;
            LSB_robIndex         <= '0;
            LSB_opcode           <= '0;
            LSB_Vj               <= '0;
            LSB_Vk               <= '0;
            LSB_Qj               <= '0;
            LSB_Qk               <= '0;
            LSB_imm              <= '0;
            LSB_pc               <= '0;
            RoB_newEntry_en      <= 1'b0;
            RoB_opcode           <= '0;
            RoB_rd               <= '0;
            RoB_pc               <= '0;
            RoB_next_pc          <= '0;
            RoB_predict          <= 1'b0;
            RoB_already_ready    <= 1'b0;
            RoB_ready_data       <= '0;
            RF_newEntry_en       <= 1'b0;
            RF_newEntry_robIndex <= '0;
            RF_newEntry_rd       <= '0;
        end else begin
            RS_newEntry_en  <= 1'b0;
            LSB_newEntry_en <= 1'b0;
            RoB_newEntry_en <= 1'b0;
            RF_newEntry_en  <= 1'b0;
            if (rdy_in && RoB_flush_signal) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (rdy_in) begin
                if (do_enq)
                    tail <= tail + 1'b1;
                if (do_deq) begin
                    head                 <= head + 1'b1;
                    RS_newEntry_en       <= !rob_only && !to_lsb;
                    LSB_newEntry_en      <= to_lsb;
                    RoB_newEntry_en      <= 1'b1;
                    RF_newEntry_en       <= !(is_branch || is_store);
                    RS_robIndex          <= RoB_newEntryIndex;
                    RS_opcode            <= h_op;
                    RS_Vj                <= vj;
                    RS_Vk                <= vk;
                    RS_Qj                <= qj;
                    RS_Qk                <= qk;
                    RS_imm               <= h_imm;
                    RS_pc                <= h_pc;
                    LSB_robIndex         <= RoB_newEntryIndex;
                    LSB_opcode           <= h_op;
                    LSB_Vj               <= vj;
                    LSB_Vk               <= vk;
                    LSB_Qj               <= qj;
                    LSB_Qk               <= qk;
                    LSB_imm              <= h_imm;
                    LSB_pc               <= h_pc;
                    RoB_opcode           <= h_op;
                    RoB_rd               <= (is_branch || is_store) ? 5'd0 : h_rd;
                    RoB_pc               <= h_pc;
                    RoB_next_pc          <= rob_npc;
                    RoB_predict          <= q_pred[head];
                    RoB_already_ready    <= rob_only;
                    RoB_ready_data       <= rob_data;
                    RF_newEntry_robIndex <= RoB_newEntryIndex;
                    RF_newEntry_rd       <= h_rd;
                end
                count <= count + {{IQ_WIDTH{1'b0}}, do_enq} - {{IQ_WIDTH{1'b0}}, do_deq};
            end
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - directed and randomized checks of dispatch_queue against a queue model
module tb_dispatch_queue;
    localparam int IQW = 2, RW = 3, NC = 2, DEPTH = 4;
    localparam logic [RW:0] ND = 4'd8;
    localparam logic [6:0] OP_LUI = 7'd1, OP_AUIPC = 7'd2, OP_JAL = 7'd3;
    localparam logic [6:0] OP_LW = 7'd13, OP_ADDI = 7'd19, OP_ADD = 7'd28;
    localparam int K_RS = 0, K_LSB = 1, K_ROB = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        pred;
    } ins_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in, in_valid, in_predict, in_ready;
    logic [31:0] in_pc, in_imm;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rs1, in_rs2, in_rd, RF_rs1, RF_rs2;
    logic [RW:0] RF_Qj, RF_Qk;
    logic [31:0] RF_Vj, RF_Vk;
    logic [NC-1:0] cdb_valid;
    logic [NC*RW-1:0] cdb_rob;
    logic [NC*32-1:0] cdb_data;
    logic RoB_isFull, RS_isFull, LSB_isFull, RoB_flush_signal;
    logic [RW-1:0] RoB_newEntryIndex;
    logic RS_newEntry_en, LSB_newEntry_en, RoB_newEntry_en, RF_newEntry_en;
    logic [RW-1:0] RS_robIndex, LSB_robIndex, RF_newEntry_robIndex;
    logic [6:0] RS_opcode, LSB_opcode, RoB_opcode;
    logic [31:0] RS_Vj, RS_Vk, RS_imm, RS_pc, LSB_Vj, LSB_Vk, LSB_imm, LSB_pc;
    logic [RW:0] RS_Qj, RS_Qk, LSB_Qj, LSB_Qk;
    logic [4:0] RoB_rd, RF_newEntry_rd;
    logic [31:0] RoB_pc, RoB_next_pc, RoB_ready_data;
    logic RoB_predict, RoB_already_ready;
    logic [IQW:0] count;

    ins_t cur;
    assign in_pc      = cur.pc;
    assign in_imm     = cur.imm;
    assign in_opcode  = cur.op;
    assign in_rs1     = cur.rs1;
    assign in_rs2     = cur.rs2;
    assign in_rd      = cur.rd;
    assign in_predict = cur.pred;

    dispatch_queue #(.IQ_WIDTH(IQW), .RoB_WIDTH(RW), .NUM_CDB(NC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .in_valid(in_valid),
        .in_pc(in_pc), .in_imm(in_imm), .in_opcode(in_opcode), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_predict(in_predict), .in_ready(in_ready),
        .RF_rs1(RF_rs1), .RF_rs2(RF_rs2), .RF_Qj(RF_Qj), .RF_Qk(RF_Qk), .RF_Vj(RF_Vj), .RF_Vk(RF_Vk),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
        .RoB_isFull(RoB_isFull), .RS_isFull(RS_isFull), .LSB_isFull(LSB_isFull),
        .RoB_flush_signal(RoB_flush_signal), .RoB_newEntryIndex(RoB_newEntryIndex),
        .RS_newEntry_en(RS_newEntry_en), .RS_robIndex(RS_robIndex), .RS_opcode(RS_opcode),
        .RS_Vj(RS_Vj), .RS_Vk(RS_Vk), .RS_Qj(RS_Qj), .RS_Qk(RS_Qk), .RS_imm(RS_imm), .RS_pc(RS_pc),
        .LSB_newEntry_en(LSB_newEntry_en), .LSB_robIndex(LSB_robIndex), .LSB_opcode(LSB_opcode),
        .LSB_Vj(LSB_Vj), .LSB_Vk(LSB_Vk), .LSB_Qj(LSB_Qj), .LSB_Qk(LSB_Qk), .LSB_imm(LSB_imm), .LSB_pc(LSB_pc),
        .RoB_newEntry_en(RoB_newEntry_en), .RoB_opcode(RoB_opcode), .RoB_rd(RoB_rd), .RoB_pc(RoB_pc),
        .RoB_next_pc(RoB_next_pc), .RoB_predict(RoB_predict), .RoB_already_ready(RoB_already_ready),
        .RoB_ready_data(RoB_ready_data), .RF_newEntry_en(RF_newEntry_en),
        .RF_newEntry_robIndex(RF_newEntry_robIndex), .RF_newEntry_rd(RF_newEntry_rd), .count(count)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad = 0;
    ins_t mq[$];
    bit e_rs, e_lsb, e_rob, e_rf;
    logic [RW-1:0] x_idx;
    logic [6:0]    x_op;
    logic [31:0]   x_vj, x_vk, x_imm, x_pc, x_npc, x_rdata;
    logic [RW:0]   x_qj, x_qk;
    logic [4:0]    x_rd, x_rf_rd;
    logic          x_pred, x_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int klass(input logic [6:0] op);
        if (op inside {[7'd1:7'd3]}) return K_ROB;
        if (op inside {[7'd11:7'd18]}) return K_LSB;
        return K_RS;
    endfunction

    task automatic exp_opnd(input logic [4:0] rs, input logic [RW:0] q, input logic [31:0] v,
                            output logic [31:0] ov, output logic [RW:0] oq);
        ov = v;
        oq = q;
        if (rs == 5'd0) begin
            ov = 32'd0;
            oq = ND;
        end else if (q != ND) begin
            for (int i = 0; i < NC; i++) begin
                if (cdb_valid[i] && cdb_rob[i*RW +: RW] == q[RW-1:0]) begin
                    ov = cdb_data[i*32 +: 32];
                    oq = ND;
                    break;
                end
            end
        end
    endtask

    // Predicts the effect of the coming clock edge from the inputs currently applied
    task automatic model_edge();
        ins_t h;
        bit enq, deq, br, st, rr;
        int k;
        e_rs = 0; e_lsb = 0; e_rob = 0; e_rf = 0;
        if (rdy_in && RoB_flush_signal) begin
            mq.delete();
        end else if (rdy_in) begin
            enq = in_valid && (mq.size() < DEPTH);
            deq = 0;
            k = K_RS;
            if (mq.size() > 0 && !RoB_isFull) begin
                k = klass(mq[0].op);
                deq = (k == K_RS) ? !RS_isFull : (k == K_LSB) ? !LSB_isFull : 1'b1;
            end
            if (deq) begin
                h = mq.pop_front();
                br = h.op inside {[7'd5:7'd10]};
                st = h.op inside {[7'd16:7'd18]};
                rr = h.op inside {[7'd28:7'd37]};
                e_rs = (k == K_RS);
                e_lsb = (k == K_LSB);
                e_rob = 1;
                e_rf = !(br || st);
                x_idx = RoB_newEntryIndex;
                x_op = h.op;
                x_imm = h.imm;
                x_pc = h.pc;
                exp_opnd(h.rs1, RF_Qj, RF_Vj, x_vj, x_qj);
                if (br || st || rr) exp_opnd(h.rs2, RF_Qk, RF_Vk, x_vk, x_qk);
                else begin
                    x_vk = 32'd0;
                    x_qk = ND;
                end
                x_rd = (br || st) ? 5'd0 : h.rd;
                x_rf_rd = h.rd;
                x_pred = h.pred;
                x_npc = (br || h.op == OP_JAL) ? h.pc + h.imm : h.pc + 32'd4;
                x_ready = (k == K_ROB);
                x_rdata = (h.op == OP_LUI) ? h.imm << 12 :
                          (h.op == OP_AUIPC) ? h.pc + (h.imm << 12) :
                          (h.op == OP_JAL) ? h.pc + 32'd4 : 32'd0;
            end
            if (enq) mq.push_back(cur);
        end
    endtask

    task automatic check_outputs();
        chk("rs_en", 32'(RS_newEntry_en), 32'(e_rs));
        chk("lsb_en", 32'(LSB_newEntry_en), 32'(e_lsb));
        chk("rob_en", 32'(RoB_newEntry_en), 32'(e_rob));
        chk("rf_en", 32'(RF_newEntry_en), 32'(e_rf));
        chk("count", 32'(count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("rf_rs1", 32'(RF_rs1), (mq.size() > 0) ? 32'(mq[0].rs1) : 32'd0);
        chk("rf_rs2", 32'(RF_rs2), (mq.size() > 0) ? 32'(mq[0].rs2) : 32'd0);
        if (e_rs) begin
            chk("rs_idx", 32'(RS_robIndex), 32'(x_idx));
            chk("rs_op", 32'(RS_opcode), 32'(x_op));
            chk("rs_vj", RS_Vj, x_vj);
            chk("rs_qj", 32'(RS_Qj), 32'(x_qj));
            chk("rs_vk", RS_Vk, x_vk);
            chk("rs_qk", 32'(RS_Qk), 32'(x_qk));
            chk("rs_imm", RS_imm, x_imm);
            chk("rs_pc", RS_pc, x_pc);
        end
        if (e_lsb) begin
            chk("lsb_idx", 32'(LSB_robIndex), 32'(x_idx));
            chk("lsb_op", 32'(LSB_opcode), 32'(x_op));
            chk("lsb_vj", LSB_Vj, x_vj);
            chk("lsb_qj", 32'(LSB_Qj), 32'(x_qj));
            chk("lsb_vk", LSB_Vk, x_vk);
            chk("lsb_qk", 32'(LSB_Qk), 32'(x_qk));
            chk("lsb_imm", LSB_imm, x_imm);
            chk("lsb_pc", LSB_pc, x_pc);
        end
        if (e_rob) begin
            chk("rob_op", 32'(RoB_opcode), 32'(x_op));
            chk("rob_rd", 32'(RoB_rd), 32'(x_rd));
            chk("rob_pc", RoB_pc, x_pc);
            chk("rob_npc", RoB_next_pc, x_npc);
            chk("rob_pred", 32'(RoB_predict), 32'(x_pred));
            chk("rob_ready", 32'(RoB_already_ready), 32'(x_ready));
            chk("rob_data", RoB_ready_data, x_rdata);
        end
        if (e_rf) begin
            chk("rf_idx", 32'(RF_newEntry_robIndex), 32'(x_idx));
            chk("rf_rd", 32'(RF_newEntry_rd), 32'(x_rf_rd));
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk_in);
        #1;
        check_outputs();
    endtask

    task automatic quiet();
        rdy_in = 1'b1; in_valid = 1'b0; RoB_flush_signal = 1'b0;
        RoB_isFull = 1'b0; RS_isFull = 1'b0; LSB_isFull = 1'b0;
        RF_Qj = ND; RF_Qk = ND; RF_Vj = 32'd0; RF_Vk = 32'd0;
        cdb_valid = '0; cdb_rob = '0; cdb_data = '0; RoB_newEntryIndex = '0;
    endtask

    task automatic offer(input logic [6:0] a_op, input logic [31:0] a_pc, input logic [31:0] a_imm,
                         input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic [4:0] a_rd);
        cur = '{pc: a_pc, imm: a_imm, op: a_op, rs1: a_rs1, rs2: a_rs2, rd: a_rd, pred: 1'b0};
        in_valid = 1'b1;
    endtask

    task automatic rand_inputs();
        cur.op   = 7'($urandom_range(1, 37));
        cur.pc   = $urandom & 32'hFFFF_FFFC;
        cur.imm  = $urandom;
        cur.rs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        cur.rs2  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        cur.rd   = 5'($urandom);
        cur.pred = 1'($urandom);
        in_valid = ($urandom_range(0, 9) < 7);
        rdy_in = ($urandom_range(0, 9) != 0);
        RoB_flush_signal = ($urandom_range(0, 39) == 0);
        RoB_isFull = ($urandom_range(0, 7) == 0);
        RS_isFull = ($urandom_range(0, 3) == 0);
        LSB_isFull = ($urandom_range(0, 3) == 0);
        RoB_newEntryIndex = 3'($urandom);
        RF_Qj = ($urandom_range(0, 2) == 0) ? ND : 4'($urandom_range(0, 3));
        RF_Qk = ($urandom_range(0, 2) == 0) ? ND : 4'($urandom_range(0, 3));
        RF_Vj = $urandom;
        RF_Vk = $urandom;
        cdb_valid = 2'($urandom);
        cdb_rob = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
        cdb_data = {$urandom, $urandom};
    endtask

    initial begin
        quiet();
        cur = '0;
        #2;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_rs_en", 32'(RS_newEntry_en), 32'd0);
        chk("reset_lsb_en", 32'(LSB_newEntry_en), 32'd0);
        chk("reset_rob_en", 32'(RoB_newEntry_en), 32'd0);
        chk("reset_rf_en", 32'(RF_newEntry_en), 32'd0);
        chk("reset_ready_flag", 32'(RoB_already_ready), 32'd0);
        chk("reset_rs_vj", RS_Vj, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Fill to capacity with RS blocked, then drain in order
        RS_isFull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(OP_ADDI, 32'h100 + 32'(4 * i), 32'(i), 5'(i + 1), 5'd0, 5'(i + 1));
            cycle();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        offer(OP_ADDI, 32'h200, 32'd7, 5'd1, 5'd0, 5'd1);
        cycle();
        in_valid = 1'b0;
        RS_isFull = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("drain_en", 32'(RS_newEntry_en), 32'd1);
            chk("drain_pc", RS_pc, 32'h100 + 32'(4 * i));
        end

        // Load blocked by full LSB, independent of a full RS
        RS_isFull = 1'b1;
        LSB_isFull = 1'b1;
        RF_Vj = 32'h1000;
        RF_Qk = 4'd2;
        offer(OP_LW, 32'h300, 32'h10, 5'd5, 5'd9, 5'd7);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("lw_stall_count", 32'(count), 32'd1);
        chk("lw_stall_en", 32'(LSB_newEntry_en), 32'd0);
        LSB_isFull = 1'b0;
        cycle();
        chk("lw_lsb_en", 32'(LSB_newEntry_en), 32'd1);
        chk("lw_rf_en", 32'(RF_newEntry_en), 32'd1);
        chk("lw_qk", 32'(LSB_Qk), 32'(ND));
        chk("lw_vj", LSB_Vj, 32'h1000);

        // CDB bypass, lowest channel wins
        quiet();
        offer(OP_ADD, 32'h400, 32'd0, 5'd1, 5'd2, 5'd3);
        cycle();
        in_valid = 1'b0;
        RF_Qj = 4'd3;
        RF_Vj = 32'h1111;
        RF_Vk = 32'h55;
        cdb_valid = 2'b11;
        cdb_rob = {3'd3, 3'd3};
        cdb_data = {32'hBBBB, 32'hAAAA};
        cycle();
        chk("byp_vj", RS_Vj, 32'hAAAA);
        chk("byp_qj", 32'(RS_Qj), 32'd8);
        chk("byp_vk", RS_Vk, 32'h55);

        // lui goes to RoB only, already resolved
        quiet();
        offer(OP_LUI, 32'h500, 32'h12345, 5'd0, 5'd0, 5'd4);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("lui_ready", 32'(RoB_already_ready), 32'd1);
        chk("lui_data", RoB_ready_data, 32'h1234_5000);
        chk("lui_rs_en", 32'(RS_newEntry_en), 32'd0);
        chk("lui_lsb_en", 32'(LSB_newEntry_en), 32'd0);
        offer(OP_AUIPC, 32'h600, 32'h1, 5'd0, 5'd0, 5'd5);
        cycle();
        offer(OP_JAL, 32'h700, 32'h20, 5'd0, 5'd0, 5'd1);
        cycle();
        in_valid = 1'b0;
        cycle();

        // rdy_in low freezes state
        RS_isFull = 1'b1;
        offer(OP_ADDI, 32'h800, 32'd1, 5'd1, 5'd0, 5'd2);
        cycle();
        RS_isFull = 1'b0;
        rdy_in = 1'b0;
        cycle();
        cycle();
        chk("frz_count", 32'(count), 32'd1);
        rdy_in = 1'b1;
        in_valid = 1'b0;
        cycle();

        // Flush with concurrent input, then asynchronous reset mid-burst
        RS_isFull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(OP_ADDI, 32'h900 + 32'(4 * i), 32'd0, 5'd1, 5'd0, 5'd1);
            cycle();
        end
        chk("pre_flush_count", 32'(count), 32'd3);
        RoB_flush_signal = 1'b1;
        cycle();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_rob_en", 32'(RoB_newEntry_en), 32'd0);
        RoB_flush_signal = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(OP_ADDI, 32'hA00 + 32'(4 * i), 32'd0, 5'd1, 5'd0, 5'd1);
            cycle();
        end
        RS_isFull = 1'b0;
        in_valid = 1'b0;
        cycle();
        chk("pre_rst_en", 32'(RS_newEntry_en), 32'd1);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_rs_en", 32'(RS_newEntry_en), 32'd0);
        chk("arst_rf_en", 32'(RF_newEntry_en), 32'd0);
        chk("arst_rob_en", 32'(RoB_newEntry_en), 32'd0);
        mq.delete();
        #1 rst_in = 1'b0;
        cycle();

        for (int n = 0; n < 800; n++) begin
            rand_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
